// File: rtl/useq_ctrl_if.sv
// Sequencer control bundle: counter readback, micro-op fields and handshakes in;
// counter controls and status out.
interface useq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] upc;
  logic [2:0]       op;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] dispatch_addr;
  logic             cond;
  logic             ready;
  logic             stall;
  logic             resume;
  logic             load;
  logic [WIDTH-1:0] preset;
  logic             ce;
  logic             halted;
  logic             fault;
  logic [1:0]       fault_code;
  logic [SPW-1:0]   depth_used;

  modport master (
    output upc, op, target, dispatch_addr, cond, ready, stall, resume,
    input  load, preset, ce, halted, fault, fault_code, depth_used
  );

  modport slave (
    input  upc, op, target, dispatch_addr, cond, ready, stall, resume,
    output load, preset, ce, halted, fault, fault_code, depth_used
  );
endinterface

// File: rtl/useq_ctrl.sv
// Microprogram sequencer control: decodes micro-ops into load/preset/ce for the
// microcode address counter, with a return stack, halt/resume and a ready timeout.
module useq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input logic        clk,
  input logic        reset,
  useq_ctrl_if.slave bus
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [SPW-1:0] DEPTH_V   = SPW'(DEPTH);
  localparam logic [WW-1:0]  WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NEXT     = 3'd0,
    OP_JUMP     = 3'd1,
    OP_JCOND    = 3'd2,
    OP_CALL     = 3'd3,
    OP_RET      = 3'd4,
    OP_DISPATCH = 3'd5,
    OP_WAITRDY  = 3'd6,
    OP_HALT     = 3'd7
  } op_t;

  state_t           state, state_nx;
  logic [SPW-1:0]   sp, sp_nx;
  logic [WW-1:0]    wait_cnt, wait_nx;
  logic [1:0]       code, code_nx;
  logic             push, pop;
  logic             load_c, ce_c;
  logic [WIDTH-1:0] pre_c;
  logic [WIDTH-1:0] ret_addr;
  logic [WIDTH-1:0] pop_val;
  logic [WIDTH-1:0] stack [DEPTH];
  op_t              op;

  assign op       = op_t'(bus.op);
  assign ret_addr = bus.upc + WIDTH'(1);
  assign pop_val  = stack[IW'(sp - 1'b1)];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_RUN;
      sp       <= '0;
      wait_cnt <= '0;
      code     <= '0;
    end else begin
      state    <= state_nx;
      sp       <= sp_nx;
      wait_cnt <= wait_nx;
      code     <= code_nx;
    end
  end

  // Stack contents need no reset: sp alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push) stack[IW'(sp)] <= ret_addr;
  end

  always_comb begin
    state_nx = state;
    sp_nx    = sp;
    wait_nx  = wait_cnt;
    code_nx  = code;
    push     = 1'b0;
    pop      = 1'b0;
    load_c   = 1'b0;
    ce_c     = 1'b0;
    pre_c    = '0;
    case (state)
      S_RUN: begin
        if (!bus.stall) begin
          wait_nx = '0;
          case (op)
            OP_NEXT: ce_c = 1'b1;
            OP_JUMP: begin
              load_c = 1'b1;
              pre_c  = bus.target;
            end
            OP_JCOND: begin
              if (bus.cond) begin
                load_c = 1'b1;
                pre_c  = bus.target;
              end else begin
                ce_c = 1'b1;
              end
            end
            OP_CALL: begin
              if (sp < DEPTH_V) begin
                push   = 1'b1;
                sp_nx  = sp + 1'b1;
                load_c = 1'b1;
                pre_c  = bus.target;
              end else begin
                state_nx = S_FAULT;
                code_nx  = 2'd1;
              end
            end
            OP_RET: begin
              if (sp != '0) begin
                pop    = 1'b1;
                sp_nx  = sp - 1'b1;
                load_c = 1'b1;
                pre_c  = pop_val;
              end else begin
                state_nx = S_FAULT;
                code_nx  = 2'd2;
              end
            end
            OP_DISPATCH: begin
              load_c = 1'b1;
              pre_c  = bus.dispatch_addr;
            end
            OP_WAITRDY: begin
              if (bus.ready) begin
                ce_c = 1'b1;
              end else if (wait_cnt == WAIT_LAST) begin
                state_nx = S_FAULT;
                code_nx  = 2'd3;
              end else begin
                wait_nx = wait_cnt + 1'b1;
              end
            end
            OP_HALT: state_nx = S_HALTED;
            default: ;
          endcase
        end
      end
      S_HALTED: begin
        if (bus.resume && !bus.stall) begin
          ce_c     = 1'b1;
          state_nx = S_RUN;
        end
      end
      default: ;
    endcase
  end

  assign bus.load       = load_c & ~reset;
  assign bus.ce         = ce_c & ~reset;
  assign bus.preset     = (load_c && !reset) ? pre_c : '0;
  assign bus.halted     = (state == S_HALTED) && !reset;
  assign bus.fault      = (state == S_FAULT) && !reset;
  assign bus.fault_code = reset ? 2'd0 : code;
  assign bus.depth_used = reset ? '0 : sp;

  logic unused_pop;
  assign unused_pop = pop;
endmodule

// File: tb/tb_useq_ctrl.sv
// Bench for useq_ctrl: directed scenarios then random ops, checked each cycle
// against a queue-based reference model driving an attached address counter.
module tb_useq_ctrl;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  useq_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  useq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Microcode address counter: sync load over ce, async reset.
  always @(posedge clk or posedge reset) begin
    if (reset)         bus.upc <= '0;
    else if (bus.load) bus.upc <= bus.preset;
    else if (bus.ce)   bus.upc <= bus.upc + 8'd1;
  end

  int tests = 0;
  int fails = 0;

  // reference model: 0 run, 1 halted, 2 fault
  int         mstate;
  int         mwait;
  int         mcode;
  logic [7:0] mstack [$];
  logic [7:0] mpc;

  logic       last_load, last_ce, last_halted, last_fault;
  logic [7:0] last_preset;
  logic [1:0] last_code;
  logic [2:0] last_depth;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mstate = 0; mwait = 0; mcode = 0; mpc = 8'd0;
    mstack.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.op = 3'd1; bus.target = 8'h5A; bus.stall = 1'b0; bus.resume = 1'b1;
    bus.cond = 1'b1; bus.ready = 1'b1; bus.dispatch_addr = 8'h33;
    #1;
    check("rst_load",  bus.load, 0);
    check("rst_ce",    bus.ce, 0);
    check("rst_pre",   bus.preset, 0);
    check("rst_halt",  bus.halted, 0);
    check("rst_fault", bus.fault, 0);
    check("rst_code",  bus.fault_code, 0);
    check("rst_depth", bus.depth_used, 0);
    bus.stall = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cycle(input logic [2:0] op_i, input logic [7:0] tgt, input logic [7:0] disp,
                          input logic c, input logic r, input logic s, input logic res);
    logic       e_load, e_ce;
    logic [7:0] e_pre;
    bus.op = op_i; bus.target = tgt; bus.dispatch_addr = disp;
    bus.cond = c; bus.ready = r; bus.stall = s; bus.resume = res;
    e_load = 1'b0; e_ce = 1'b0; e_pre = 8'd0;
    if (mstate == 0 && !s) begin
      case (op_i)
        3'd0: e_ce = 1'b1;
        3'd1: begin e_load = 1'b1; e_pre = tgt; end
        3'd2: if (c) begin e_load = 1'b1; e_pre = tgt; end else e_ce = 1'b1;
        3'd3: if (mstack.size() < DEPTH) begin e_load = 1'b1; e_pre = tgt; end
        3'd4: if (mstack.size() > 0) begin e_load = 1'b1; e_pre = mstack[$]; end
        3'd5: begin e_load = 1'b1; e_pre = disp; end
        3'd6: e_ce = r;
        default: ;
      endcase
    end else if (mstate == 1 && res && !s) begin
      e_ce = 1'b1;
    end
    @(negedge clk);
    last_load = bus.load; last_ce = bus.ce; last_preset = bus.preset;
    last_halted = bus.halted; last_fault = bus.fault;
    last_code = bus.fault_code; last_depth = bus.depth_used;
    check("upc",    bus.upc, mpc);
    check("load",   last_load, e_load);
    check("ce",     last_ce, e_ce);
    check("preset", last_preset, e_pre);
    check("halted", last_halted, mstate == 1);
    check("fault",  last_fault, mstate == 2);
    check("code",   last_code, mcode);
    check("depth",  last_depth, mstack.size());
    @(posedge clk);
    if (mstate == 0 && !s) begin
      case (op_i)
        3'd3: if (mstack.size() < DEPTH) mstack.push_back(mpc + 8'd1);
              else begin mstate = 2; mcode = 1; end
        3'd4: if (mstack.size() > 0) void'(mstack.pop_back());
              else begin mstate = 2; mcode = 2; end
        3'd6: if (r) mwait = 0;
              else if (mwait < TIMEOUT - 1) mwait++;
              else begin mstate = 2; mcode = 3; mwait = 0; end
        3'd7: mstate = 1;
        default: ;
      endcase
      if (op_i != 3'd6) mwait = 0;
    end else if (mstate == 1 && res && !s) begin
      mstate = 0;
    end
    if (e_load) mpc = e_pre;
    else if (e_ce) mpc = mpc + 8'd1;
    #1;
  endtask

  initial begin
    bus.op = 3'd0; bus.target = '0; bus.dispatch_addr = '0;
    bus.cond = 1'b0; bus.ready = 1'b0; bus.stall = 1'b1; bus.resume = 1'b0;
    model_reset();
    do_reset();

    // sequential fetch
    for (int i = 0; i < 3; i++) do_cycle(3'd0, 8'h00, 8'h00, 0, 0, 0, 0);
    do_cycle(3'd0, 8'h00, 8'h00, 0, 0, 1, 0);
    check("seq_upc", bus.upc, 3);

    // call / return
    do_cycle(3'd1, 8'h10, 8'h00, 0, 0, 0, 0);
    do_cycle(3'd3, 8'h40, 8'h00, 0, 0, 0, 0);
    check("call_load", last_load, 1);
    check("call_pre",  last_preset, 8'h40);
    do_cycle(3'd1, 8'h45, 8'h00, 0, 0, 0, 0);
    check("call_depth", last_depth, 1);
    do_cycle(3'd4, 8'h00, 8'h00, 0, 0, 0, 0);
    check("ret_pre", last_preset, 8'h11);
    do_cycle(3'd0, 8'h00, 8'h00, 0, 0, 0, 0);
    check("ret_depth", last_depth, 0);

    // return-address wrap
    do_cycle(3'd1, 8'hFF, 8'h00, 0, 0, 0, 0);
    do_cycle(3'd3, 8'h80, 8'h00, 0, 0, 0, 0);
    do_cycle(3'd4, 8'h00, 8'h00, 0, 0, 0, 0);
    check("wrap_pre", last_preset, 8'h00);

    // overflow
    for (int i = 0; i < 5; i++) do_cycle(3'd3, 8'h20 + 8'(i), 8'h00, 0, 0, 0, 0);
    check("ovf_load", last_load, 0);
    check("ovf_ce",   last_ce, 0);
    for (int i = 0; i < 3; i++) do_cycle(3'($urandom_range(0, 7)), 8'h00, 8'h00, 1, 1, 0, 1);
    check("ovf_fault", last_fault, 1);
    check("ovf_code",  last_code, 1);
    check("ovf_depth", last_depth, 4);
    do_reset();
    do_cycle(3'd0, 8'h00, 8'h00, 0, 0, 0, 0);
    check("clr_fault", last_fault, 0);
    check("clr_depth", last_depth, 0);

    // underflow
    do_cycle(3'd4, 8'h00, 8'h00, 0, 0, 0, 0);
    do_cycle(3'd0, 8'h00, 8'h00, 0, 0, 0, 0);
    check("unf_code", last_code, 2);
    do_reset();

    // wait for ready, in time then timing out
    for (int i = 0; i < 5; i++) do_cycle(3'd6, 8'h00, 8'h00, 0, 0, 0, 0);
    do_cycle(3'd6, 8'h00, 8'h00, 0, 1, 0, 0);
    check("wait_ce", last_ce, 1);
    for (int i = 0; i < 16; i++) do_cycle(3'd6, 8'h00, 8'h00, 0, 0, 0, 0);
    check("wait_nofault", last_fault, 0);
    do_cycle(3'd0, 8'h00, 8'h00, 0, 0, 0, 0);
    check("to_fault", last_fault, 1);
    check("to_code",  last_code, 3);
    do_reset();

    // halt / resume
    do_cycle(3'd7, 8'h00, 8'h00, 0, 0, 0, 0);
    do_cycle(3'd0, 8'h00, 8'h00, 0, 0, 0, 0);
    check("halt_on", last_halted, 1);
    do_cycle(3'd0, 8'h00, 8'h00, 0, 0, 1, 1);
    do_cycle(3'd0, 8'h00, 8'h00, 0, 0, 0, 1);
    check("res_ce", last_ce, 1);
    do_cycle(3'd0, 8'h00, 8'h00, 0, 0, 0, 0);
    check("res_run", last_halted, 0);

    // conditional jump and stall
    do_cycle(3'd2, 8'h20, 8'h00, 1, 0, 0, 0);
    check("jc_pre", last_preset, 8'h20);
    do_cycle(3'd2, 8'h20, 8'h00, 0, 0, 0, 0);
    check("jc_ce", last_ce, 1);
    do_cycle(3'd3, 8'h50, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) do_cycle(3'(i), 8'h77, 8'h66, 1, 0, 1, 1);
    check("stall_depth", last_depth, 1);
    do_cycle(3'd5, 8'h00, 8'h9C, 0, 0, 0, 0);
    check("disp_pre", last_preset, 8'h9C);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if ((mstate == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 60) == 0) do_reset();
      else do_cycle(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                    1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0,
                    1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
